alu_seq: RTL

- Parametrised, handshaked execute unit for the processor pipeline.
- Performs the base integer ops (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND) with a registered 1-cycle result.
- Performs the RV32M-style multiply/divide ops iteratively over WIDTH cycles.
- Sits in EX; the pipeline stalls on `in_ready` / `out_valid`.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle between the pipeline and the execute unit
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       alu_op;
  logic             option_bit;
  logic             md_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             busy;
  modport master (
    output in_valid, in_a, in_b, alu_op, option_bit, md_sel, out_ready,
    input  in_ready, out_valid, out_result, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, alu_op, option_bit, md_sel, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute unit with 1-cycle base ops and WIDTH-cycle multiply/divide
module alu_seq #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  input logic      flush,
  alu_seq_if.slave bus
);
  localparam int CW = SHAMT_W + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             r_state;
  logic               r_out_valid, r_busy, r_sa, r_sb;
  logic [WIDTH-1:0]   r_result, r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [2:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic               w_accept, w_mul_in, w_sa, w_sb, w_special, w_mul, w_ge;
  logic [SHAMT_W-1:0] w_sh;
  logic [WIDTH-1:0]   w_ma, w_mb, w_base, w_sra, w_fast, w_sub, w_quo, w_rem, w_final;
  logic [WIDTH:0]     w_sum, w_rsh;
  logic [2*WIDTH-1:0] w_step, w_prod;
  assign bus.in_ready   = !flush && (r_state == IDLE || (r_state == DONE && bus.out_ready));
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_result;
  assign bus.busy       = r_busy;
  assign w_accept = bus.in_valid && bus.in_ready;
  // Operand signedness: MULH/MULHSU sign A, MULH signs B; DIV/REM sign both
  assign w_mul_in = !bus.alu_op[2];
  assign w_sa = bus.in_a[WIDTH-1] && (w_mul_in ? (bus.alu_op[1] ^ bus.alu_op[0]) : !bus.alu_op[0]);
  assign w_sb = bus.in_b[WIDTH-1] && (w_mul_in ? (bus.alu_op[1:0] == 2'b01) : !bus.alu_op[0]);
  assign w_ma = w_sa ? -bus.in_a : bus.in_a;
  assign w_mb = w_sb ? -bus.in_b : bus.in_b;
  assign w_special = bus.md_sel && bus.alu_op[2] &&
                     (bus.in_b == '0 || (!bus.alu_op[0] && bus.in_a == MIN_NEG && bus.in_b == '1));
  assign w_sh  = bus.in_b[SHAMT_W-1:0];
  assign w_sra = $signed(bus.in_a) >>> w_sh;
  always_comb begin
    w_base = '0;
    case (bus.alu_op)
      3'b000: w_base = bus.option_bit ? bus.in_a - bus.in_b : bus.in_a + bus.in_b;
      3'b001: w_base = bus.in_a << w_sh;
      3'b010: w_base = {{(WIDTH-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      3'b011: w_base = {{(WIDTH-1){1'b0}}, bus.in_a < bus.in_b};
      3'b100: w_base = bus.in_a ^ bus.in_b;
      3'b101: w_base = bus.option_bit ? w_sra : bus.in_a >> w_sh;
      3'b110: w_base = bus.in_a | bus.in_b;
      default: w_base = bus.in_a & bus.in_b;
    endcase
  end
  assign w_fast = !bus.md_sel ? w_base :
                  bus.in_b == '0 ? (bus.alu_op[1] ? bus.in_a : '1) :
                  (bus.alu_op[1] ? '0 : bus.in_a);
  // Multiply: shift-add into {hi,lo}; divide: restoring step on {rem,quo}
  assign w_mul  = !r_op[2];
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_acc[0] ? r_m : {WIDTH{1'b0}}};
  assign w_rsh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge   = w_rsh >= {1'b0, r_m};
  assign w_sub  = w_rsh[WIDTH-1:0] - r_m;
  assign w_step = w_mul ? {w_sum, r_acc[WIDTH-1:1]} :
                  {w_ge ? w_sub : w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  assign w_prod  = (r_sa ^ r_sb) ? -w_step : w_step;
  assign w_quo   = (r_sa ^ r_sb) ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
  assign w_rem   = r_sa ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
  assign w_final = w_mul ? (r_op[1:0] == 2'b00 ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH]) :
                   (r_op[1] ? w_rem : w_quo);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_m         <= '0;
      r_acc       <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_op <= bus.alu_op;
      r_sa <= w_sa;
      r_sb <= w_sb;
      if (bus.md_sel && !w_special) begin
        r_state     <= BUSY;
        r_busy      <= 1'b1;
        r_out_valid <= 1'b0;
        r_cnt       <= CW'(WIDTH);
        r_m         <= w_mul_in ? w_ma : w_mb;
        r_acc       <= {{WIDTH{1'b0}}, w_mul_in ? w_mb : w_ma};
      end else begin
        r_state     <= DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_fast;
      end
    end else if (r_state == DONE && bus.out_ready) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else if (r_state == BUSY) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_state     <= DONE;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b1;
        r_result    <= w_final;
      end
    end
  end
endmodule
